// File: rtl/accel_spi_responder.sv
// SPI mode-0 slave modelling an ADXL362-style register interface on clk_alm.
// Sensor samples are double-buffered so that an SPI burst always sees one coherent sample.
//
//   state     | meaning
//   ST_IDLE   | CS high, waiting for CS low
//   ST_CMD    | shifting in the command byte
//   ST_ADDR   | shifting in the register address
//   ST_DATA   | streaming register bytes (read or write), auto-increment address
//   ST_IGNORE | unknown command, SO held low until CS rises
module accel_spi_responder #(
   parameter logic [7:0] DEVID_AD   = 8'hAD,
   parameter logic [7:0] DEVID_MST  = 8'h1D,
   parameter logic [7:0] PARTID     = 8'hF2,
   parameter logic [7:0] FILTER_RST = 8'h13
) (
   input  logic       clk_alm,
   input  logic       rst_n,
   input  logic       CS,
   input  logic       SCLK,
   input  logic       SI,
   output logic       SO,
   input  logic       sample_valid,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   input  logic [7:0] z_in,
   output logic [7:0] power_ctl,
   output logic [7:0] filter_ctl,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_IGNORE
   } state_t;

   localparam logic [7:0] CMD_READ  = 8'h0B;
   localparam logic [7:0] CMD_WRITE = 8'h0A;

   state_t      state;
   logic        sclk_d;
   logic        cs_d;
   logic [2:0]  bit_cnt;
   logic [7:0]  rx;
   logic        rd_mode;
   logic [5:0]  addr;
   logic [7:0]  tx_sh;
   logic [7:0]  xdata;
   logic [7:0]  ydata;
   logic [7:0]  zdata;
   logic        data_ready;
   logic [23:0] pend;
   logic        pend_v;

   logic        rise;
   logic        fall;
   logic        cs_rise;
   logic        byte_done;
   logic [7:0]  rx_next;
   logic [5:0]  rd_sel;
   logic [7:0]  rd_data;
   logic        load_x;

   always_comb begin
      rise      = SCLK & ~sclk_d & ~CS;
      fall      = ~SCLK & sclk_d & ~CS;
      cs_rise   = CS & ~cs_d;
      rx_next   = {rx[6:0], SI};
      byte_done = rise && (bit_cnt == 3'd7);
   end

   // The first read byte is fetched from the address still being shifted in.
   always_comb begin
      rd_sel = (state == ST_ADDR) ? rx_next[5:0] : addr;
      case (rd_sel)
         6'h00:   rd_data = DEVID_AD;
         6'h01:   rd_data = DEVID_MST;
         6'h02:   rd_data = PARTID;
         6'h08:   rd_data = xdata;
         6'h09:   rd_data = ydata;
         6'h0A:   rd_data = zdata;
         6'h0B:   rd_data = {7'd0, data_ready};
         6'h2C:   rd_data = filter_ctl;
         6'h2D:   rd_data = power_ctl;
         default: rd_data = 8'h00;
      endcase
   end

   always_comb begin
      load_x = byte_done && rd_mode && (rd_sel == 6'h08) &&
               ((state == ST_ADDR) || (state == ST_DATA));
   end

   always_ff @(posedge clk_alm) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         sclk_d     <= 1'b0;
         cs_d       <= 1'b1;
         bit_cnt    <= 3'd0;
         rx         <= 8'h00;
         rd_mode    <= 1'b0;
         addr       <= 6'd0;
         tx_sh      <= 8'h00;
         SO         <= 1'b0;
         busy       <= 1'b0;
         xdata      <= 8'h00;
         ydata      <= 8'h00;
         zdata      <= 8'h00;
         data_ready <= 1'b0;
         pend       <= 24'd0;
         pend_v     <= 1'b0;
         power_ctl  <= 8'h00;
         filter_ctl <= FILTER_RST;
      end else begin
         sclk_d <= SCLK;
         cs_d   <= CS;
         busy   <= ~CS;

         // Clear before set so a coincident sample load keeps DATA_READY high.
         if (load_x)
            data_ready <= 1'b0;

         if (sample_valid && CS) begin
            xdata      <= x_in;
            ydata      <= y_in;
            zdata      <= z_in;
            data_ready <= 1'b1;
            pend_v     <= 1'b0;
         end else if (sample_valid) begin
            pend   <= {x_in, y_in, z_in};
            pend_v <= 1'b1;
         end else if (cs_rise && pend_v) begin
            xdata      <= pend[23:16];
            ydata      <= pend[15:8];
            zdata      <= pend[7:0];
            data_ready <= 1'b1;
            pend_v     <= 1'b0;
         end

         if (CS) begin
            state <= ST_IDLE;
            SO    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state   <= ST_CMD;
                  bit_cnt <= 3'd0;
               end
               ST_CMD: begin
                  if (rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        if (rx_next == CMD_READ) begin
                           rd_mode <= 1'b1;
                           state   <= ST_ADDR;
                        end else if (rx_next == CMD_WRITE) begin
                           rd_mode <= 1'b0;
                           state   <= ST_ADDR;
                        end else begin
                           state <= ST_IGNORE;
                        end
                     end
                  end
               end
               ST_ADDR: begin
                  if (rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (byte_done) begin
                        state <= ST_DATA;
                        if (rd_mode) begin
                           tx_sh <= rd_data;
                           addr  <= rx_next[5:0] + 6'd1;
                        end else begin
                           addr <= rx_next[5:0];
                        end
                     end
                  end
               end
               ST_DATA: begin
                  if (rise) begin
                     rx      <= rx_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (rd_mode) begin
                        if (byte_done) begin
                           tx_sh <= rd_data;
                           addr  <= addr + 6'd1;
                        end else begin
                           tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                     end else if (byte_done) begin
                        case (addr)
                           6'h2C:   filter_ctl <= rx_next;
                           6'h2D:   power_ctl  <= rx_next;
                           default: ;
                        endcase
                        addr <= addr + 6'd1;
                     end
                  end
                  if (fall && rd_mode)
                     SO <= tx_sh[7];
               end
               ST_IGNORE: begin
                  SO <= 1'b0;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Self-checking bench for accel_spi_responder: table-driven register transactions
// plus hand-written sample-buffering, partial-transfer and reset sequences.
module tb_accel_spi_responder;

   logic       clk_alm = 1'b0;
   logic       rst_n   = 1'b0;
   logic       CS      = 1'b1;
   logic       SCLK    = 1'b0;
   logic       SI      = 1'b0;
   logic       SO;
   logic       sample_valid = 1'b0;
   logic [7:0] x_in = 8'h00;
   logic [7:0] y_in = 8'h00;
   logic [7:0] z_in = 8'h00;
   logic [7:0] power_ctl;
   logic [7:0] filter_ctl;
   logic       busy;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      bit         wr;
      logic [7:0] cmd;
      logic [7:0] addr;
      int         n;
      logic [7:0] d [4];
      logic [7:0] pwr;
      logic [7:0] flt;
   } vec_t;

   vec_t vecs [13];

   accel_spi_responder dut (
      .clk_alm      (clk_alm),
      .rst_n        (rst_n),
      .CS           (CS),
      .SCLK         (SCLK),
      .SI           (SI),
      .SO           (SO),
      .sample_valid (sample_valid),
      .x_in         (x_in),
      .y_in         (y_in),
      .z_in         (z_in),
      .power_ctl    (power_ctl),
      .filter_ctl   (filter_ctl),
      .busy         (busy)
   );

   always #5 clk_alm = ~clk_alm;

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk_alm);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", nm, act, exp);
      end
   endtask

   task automatic sb_pop(input string nm, input logic [7:0] act);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got %02h with no expected byte queued", nm, act);
      end else begin
         chk(nm, act, exp_q.pop_front());
      end
   endtask

   // SO is sampled at the end of the low phase, i.e. before the rise that consumes it.
   task automatic xfer_bits(input logic [7:0] out, input int nb, output logic [7:0] in);
      in = 8'h00;
      for (int i = 0; i < nb; i++) begin
         SI   = out[7-i];
         SCLK = 1'b0;
         clk_n(3);
         in[7-i] = SO;
         SCLK = 1'b1;
         clk_n(3);
      end
   endtask

   task automatic xfer(input logic [7:0] out, output logic [7:0] in);
      xfer_bits(out, 8, in);
   endtask

   task automatic cs_low();
      CS = 1'b0;
      clk_n(3);
   endtask

   task automatic cs_high();
      SCLK = 1'b0;
      clk_n(3);
      CS = 1'b1;
      clk_n(3);
   endtask

   task automatic pulse(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
      x_in = x;
      y_in = y;
      z_in = z;
      sample_valid = 1'b1;
      clk_n(1);
      sample_valid = 1'b0;
   endtask

   task automatic rd_txn(input string nm, input logic [7:0] cmd, input logic [7:0] a, input int n);
      logic [7:0] rb;
      cs_low();
      xfer(cmd, rb);
      xfer(a, rb);
      for (int k = 0; k < n; k++) begin
         xfer(8'h00, rb);
         sb_pop(nm, rb);
      end
      cs_high();
   endtask

   initial begin
      logic [7:0] rb;

      vecs[0]  = '{1'b0, 8'h0B, 8'h00, 3, '{8'hAD, 8'h1D, 8'hF2, 8'h00}, 8'h00, 8'h13};
      vecs[1]  = '{1'b0, 8'h0B, 8'h2C, 2, '{8'h13, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h13};
      vecs[2]  = '{1'b1, 8'h0A, 8'h2D, 1, '{8'h02, 8'h00, 8'h00, 8'h00}, 8'h02, 8'h13};
      vecs[3]  = '{1'b0, 8'h0B, 8'h2D, 1, '{8'h02, 8'h00, 8'h00, 8'h00}, 8'h02, 8'h13};
      vecs[4]  = '{1'b1, 8'h0A, 8'h00, 1, '{8'h55, 8'h00, 8'h00, 8'h00}, 8'h02, 8'h13};
      vecs[5]  = '{1'b0, 8'h0B, 8'h00, 1, '{8'hAD, 8'h00, 8'h00, 8'h00}, 8'h02, 8'h13};
      vecs[6]  = '{1'b1, 8'h0A, 8'h2C, 2, '{8'h44, 8'h0A, 8'h00, 8'h00}, 8'h0A, 8'h44};
      vecs[7]  = '{1'b0, 8'h0B, 8'h2C, 2, '{8'h44, 8'h0A, 8'h00, 8'h00}, 8'h0A, 8'h44};
      vecs[8]  = '{1'b0, 8'h0B, 8'h3F, 2, '{8'h00, 8'hAD, 8'h00, 8'h00}, 8'h0A, 8'h44};
      vecs[9]  = '{1'b0, 8'h0C, 8'h2D, 2, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h0A, 8'h44};
      vecs[10] = '{1'b0, 8'h0B, 8'h0B, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h0A, 8'h44};
      vecs[11] = '{1'b1, 8'h0A, 8'h3E, 1, '{8'hFF, 8'h00, 8'h00, 8'h00}, 8'h0A, 8'h44};
      vecs[12] = '{1'b0, 8'h0B, 8'h3E, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 8'h0A, 8'h44};

      clk_n(3);
      chk("reset_so", {7'd0, SO}, 8'h00);
      chk("reset_busy", {7'd0, busy}, 8'h00);
      chk("reset_pwr", power_ctl, 8'h00);
      chk("reset_flt", filter_ctl, 8'h13);
      rst_n = 1'b1;
      clk_n(3);

      for (int v = 0; v < 13; v++) begin
         if (vecs[v].wr) begin
            cs_low();
            xfer(vecs[v].cmd, rb);
            xfer(vecs[v].addr, rb);
            for (int k = 0; k < vecs[v].n; k++)
               xfer(vecs[v].d[k], rb);
            cs_high();
         end else begin
            for (int k = 0; k < vecs[v].n; k++)
               exp_q.push_back(vecs[v].d[k]);
            rd_txn($sformatf("vec%0d_rd", v), vecs[v].cmd, vecs[v].addr, vecs[v].n);
         end
         chk($sformatf("vec%0d_pwr", v), power_ctl, vecs[v].pwr);
         chk($sformatf("vec%0d_flt", v), filter_ctl, vecs[v].flt);
      end

      // Direct sample load while idle, then STATUS clears once XDATA is fetched.
      pulse(8'h5A, 8'h6B, 8'h7C);
      exp_q.push_back(8'h01);
      rd_txn("status_set", 8'h0B, 8'h0B, 1);
      exp_q.push_back(8'h5A); exp_q.push_back(8'h6B); exp_q.push_back(8'h7C);
      rd_txn("xyz_direct", 8'h0B, 8'h08, 3);
      exp_q.push_back(8'h00);
      rd_txn("status_clr", 8'h0B, 8'h0B, 1);

      // Samples arriving mid-burst stay pending; the newest lands at CS rise.
      cs_low();
      chk("busy_cs_low", {7'd0, busy}, 8'h01);
      xfer(8'h0B, rb);
      xfer(8'h08, rb);
      exp_q.push_back(8'h5A); exp_q.push_back(8'h6B); exp_q.push_back(8'h7C);
      xfer(8'h00, rb); sb_pop("burst_old_x", rb);
      pulse(8'h11, 8'h12, 8'h13);
      xfer(8'h00, rb); sb_pop("burst_old_y", rb);
      pulse(8'h22, 8'h33, 8'h44);
      xfer(8'h00, rb); sb_pop("burst_old_z", rb);
      cs_high();
      exp_q.push_back(8'h01);
      rd_txn("status_pend", 8'h0B, 8'h0B, 1);
      exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      rd_txn("xyz_pend", 8'h0B, 8'h08, 3);

      // Sample on the CS-rise cycle beats the pending one and discards it.
      cs_low();
      xfer(8'h0B, rb);
      xfer(8'h08, rb);
      exp_q.push_back(8'h22);
      xfer(8'h00, rb); sb_pop("collide_burst", rb);
      pulse(8'h55, 8'h66, 8'h77);
      SCLK = 1'b0;
      clk_n(3);
      x_in = 8'h99; y_in = 8'h88; z_in = 8'h77;
      sample_valid = 1'b1;
      CS = 1'b1;
      clk_n(1);
      sample_valid = 1'b0;
      clk_n(3);
      exp_q.push_back(8'h99);
      rd_txn("collide_new", 8'h0B, 8'h08, 1);
      exp_q.push_back(8'h99);
      rd_txn("collide_nopend", 8'h0B, 8'h08, 1);

      // Partial write byte is discarded, next transaction decodes normally.
      cs_low();
      xfer(8'h0A, rb);
      xfer(8'h2D, rb);
      xfer_bits(8'hFF, 4, rb);
      cs_high();
      chk("partial_pwr", power_ctl, 8'h0A);
      exp_q.push_back(8'h0A);
      rd_txn("after_partial", 8'h0B, 8'h2D, 1);

      // Reset mid-transfer.
      cs_low();
      xfer(8'h0A, rb);
      xfer(8'h2D, rb);
      xfer_bits(8'hF0, 4, rb);
      rst_n = 1'b0;
      CS = 1'b1;
      SCLK = 1'b0;
      clk_n(2);
      chk("midrst_pwr", power_ctl, 8'h00);
      chk("midrst_flt", filter_ctl, 8'h13);
      chk("midrst_busy", {7'd0, busy}, 8'h00);
      chk("midrst_so", {7'd0, SO}, 8'h00);
      rst_n = 1'b1;
      clk_n(3);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      rd_txn("midrst_data", 8'h0B, 8'h0B, 2);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL sb_leftover: got %0d unconsumed bytes expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
